// File: rtl/fnd_scan_controller_if.sv
// ============================================================================
//  Module   : fnd_scan_controller_if
//  Brief    : Display data and FND pin bundle for the 4-digit scan controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fnd_scan_controller_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [3:0]  com;
  logic        digit_tick;
  logic        frame_done;

  // Datapath side: supplies the number, observes the pins.
  modport master (
    output enable, value, dp_in, blank_lz,
    input  seg, com, digit_tick, frame_done
  );

  // Controller side.
  modport slave (
    input  enable, value, dp_in, blank_lz,
    output seg, com, digit_tick, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/fnd_scan_controller.sv
// ============================================================================
//  Module   : fnd_scan_controller
//  Brief    : Time-multiplexed scan of a 4-digit common-anode 7-segment display
//             with dead-time between digits and leading-zero blanking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  wire                  clk,
  input  wire                  reset_p,
  fnd_scan_controller_if.slave bus
);

  // One counter times both SHOW and GAP, so size it for the longer of the two.
  localparam int MAX_CNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW      = $clog2(MAX_CNT);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0]   shadow, shadow_nx;
  logic [3:0]    shadow_dp, shadow_dp_nx;
  logic          latch;

  logic [7:0]    seg_q, seg_nx;
  logic [3:0]    com_q, com_nx;
  logic          tick_q, tick_nx;
  logic          done_q, done_nx;
  logic [3:0]    nibble;
  logic          blank;

  // Active-low hex decode, segment order g..a.
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h58;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  // Next-state, counters and shadow latch; enable low forces everything back to IDLE.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    latch    = 1'b0;
    if (!bus.enable) begin
      state_nx = IDLE;
      idx_nx   = 2'd0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SHOW;
          idx_nx   = 2'd0;
          cnt_nx   = '0;
          latch    = 1'b1;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nx = GAP;
            idx_nx   = idx + 2'd1;
            cnt_nx   = '0;
          end else begin
            cnt_nx   = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
            // New frame only ever starts here, so the display cannot tear mid-frame.
            latch    = (idx == 2'd0);
          end else begin
            cnt_nx   = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = 2'd0;
          cnt_nx   = '0;
        end
      endcase
    end
    shadow_nx    = latch ? bus.value : shadow;
    shadow_dp_nx = latch ? bus.dp_in : shadow_dp;
  end

  // Output values for the upcoming cycle, derived from next-state so the pins line up with it.
  always_comb begin
    com_nx  = 4'b1111;
    seg_nx  = 8'hFF;
    tick_nx = 1'b0;
    done_nx = 1'b0;
    nibble  = shadow_nx[{idx_nx, 2'b00} +: 4];
    blank   = bus.blank_lz && (idx_nx != 2'd0) &&
              ((shadow_nx >> {idx_nx, 2'b00}) == 16'h0000);
    if (state_nx == SHOW) begin
      com_nx  = ~(4'b0001 << idx_nx);
      seg_nx  = {~shadow_dp_nx[idx_nx], blank ? 7'h7F : decode(nibble)};
      tick_nx = (cnt_nx == '0);
      done_nx = (cnt_nx == SHOW_LAST) && (idx_nx == 2'd3);
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'b0000;
      seg_q     <= 8'hFF;
      com_q     <= 4'b1111;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      shadow    <= shadow_nx;
      shadow_dp <= shadow_dp_nx;
      seg_q     <= seg_nx;
      com_q     <= com_nx;
      tick_q    <= tick_nx;
      done_q    <= done_nx;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.com        = com_q;
  assign bus.digit_tick = tick_q;
  assign bus.frame_done = done_q;

endmodule

`default_nettype wire
